// File: rtl/sram_arbiter.sv
// Two-requester arbiter and single-outstanding sequencer in front of the SRAM controller.
// Round-robin or fixed-priority grant, busy back-pressure, and a watchdog on completion.
module sram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          done0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          owner,
  output logic          active,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid,
  input  logic          mem_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt1;
  logic          ack0_c, ack1_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    if (FIXED_PRIO != 0) gnt1 = req1 & ~req0;
    else                 gnt1 = req1 & (~req0 | ~last_q);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    ack0_c  = 1'b0;
    ack1_c  = 1'b0;
    mem_wr  = 1'b0;
    mem_rd  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          owner_d = gnt1;
          last_d  = gnt1;
          we_d    = gnt1 ? we1 : we0;
          addr_d  = gnt1 ? addr1 : addr0;
          wdata_d = gnt1 ? wdata1 : wdata0;
          ack0_c  = ~gnt1;
          ack1_c  = gnt1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!mem_busy) begin
          mem_wr  = we_q;
          mem_rd  = ~we_q;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_valid) begin
          if (!we_q) rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant is combinational in IDLE; suppress it while reset is held.
  assign ack0      = ack0_c & ~rst;
  assign ack1      = ack1_c & ~rst;
  assign done0     = (state_q == S_RESP) & ~owner_q;
  assign done1     = (state_q == S_RESP) & owner_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign owner     = owner_q;
  assign active    = (state_q != S_IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
